psum_ofifo: RTL and testbench
=============================

// Module: psum_ofifo
// PURPOSE
//  Output FIFO directly downstream of the systolic MAC row array.
//  Captures each column's dual psum pair when that column's valid bit fires.
//  Columns arrive skewed by one cycle each; the block re-aligns them and releases a full row only when every column holds data.
//  Consumer (SFU/accumulator) pops whole aligned rows with rd.
// PARAMETERS
//  col      8   number of columns; matches the MAC row width
//  psum_bw  9   width of one psum; each column entry is 2*psum_bw bits
//  depth    16  entries per column FIFO; must be a power of 2, >=2
// PORTS
//  clk      in   1              rising-edge clock
//  reset    in   1              asynchronous, active-low; reset asserted when 0
//  in       in   2*psum_bw*col  dual psums; column i at [2*psum_bw*(i+1)-1 : 2*psum_bw*i]
//  wr       in   col            per-column write strobe (MAC row valid)
//  rd       in   1              pop one aligned row
//  out      out  2*psum_bw*col  popped row; same packing as in
//  o_valid  out  1              every column FIFO is non-empty
//  o_ready  out  1              no column FIFO is full
//  o_full   out  1              at least one column FIFO is full (= !o_ready)
// BEHAVIOUR
//  Reset (reset==0, async)
//   - All rd/wr pointers go to 0; out = 0; o_valid = 0; o_ready = 1; o_full = 0.
//   - Storage contents are not cleared.
//   - Reset mid-stream discards all queued entries; the first write after release lands in slot 0.
//  Pointers
//   - Per column, wr_ptr and rd_ptr are each log2(depth)+1 bits; they wrap modulo 2*depth.
//   - empty_i = (wr_ptr == rd_ptr).
//   - full_i = MSBs differ and low bits are equal.
//  Write
//   - On a clk edge with wr[i]=1: column i stores its in slice at wr_ptr and increments wr_ptr.
//   - Accepted if !full_i, or if full_i and a pop of that column occurs in the same cycle.
//   - Otherwise the write is dropped and wr_ptr is unchanged.
//   - Columns write independently; any subset of wr may be set in a cycle.
//  Read
//   - A pop occurs when rd && o_valid. All columns advance rd_ptr together.
//   - out registers the head entries on that same edge: 1-cycle latency, data visible the cycle after rd.
//   - out holds its value when there is no pop.
//   - rd while !o_valid is ignored: no pointer change, out held.
//  Simultaneous wr[i] and pop on column i: both take effect; occupancy of column i is unchanged.
//  Flags
//   - o_valid, o_ready and o_full are combinational from the pointers.
//   - A write and a pop in cycle t are reflected in the flags in cycle t+1.
// CONFIGURATION
//  Macro PSUM_OFIFO_ERR_EN
//   - Defined: adds output ports o_ovf (1) and o_drop_cnt (8).
//   - o_ovf is a sticky flag, set on any dropped write.
//   - o_drop_cnt counts dropped column-writes and saturates at 255.
//   - Both are cleared only by reset.
//   - Not defined: ports absent; dropped writes are silent.
// STRUCTURE
//  Package psum_ofifo_pkg
//   - Default constants COL, PSUM_BW, DEPTH.
//   - Function clog2.
//   - Localparam ENTRY_BW = 2*PSUM_BW.
//  Sub-module psum_col_fifo
//   - One synchronous single-column FIFO of width ENTRY_BW and depth depth.
//   - Exposes empty, full and the head entry; rd input driven by the shared pop.
//   - Top level generates col instances, AND-reduces !empty into o_valid and OR-reduces full into o_full.
//   - Top level owns the out register.
// TESTING
//  1 Reset with wr=0xFF and in=all 0x1: flags 1/0/0 (o_ready/o_valid/o_full), out=0; nothing is written while reset==0.
//  2 Skewed fill: wr bit i set at cycle i, col i data=0x10+i (cols 0..7).
//     - o_valid rises only the cycle after col 7 writes.
//     - rd=1 -> next cycle out holds 0x10..0x17 per column; o_valid falls.
//  3 Fill col 0 with 16 writes (values 0..15) and the others with 1 write each.
//     - o_full=1, o_ready=0.
//     - 17th col-0 write (no pop) is dropped; with PSUM_OFIFO_ERR_EN, o_ovf=1 and o_drop_cnt=1.
//  4 Col 0 full, all others non-empty: same-cycle wr[0]=1 and rd=1.
//     - out col0 = 0 next cycle, write accepted, col 0 still full.
//  5 Wrap: stream 40 rows continuously with rd asserted each cycle once o_valid.
//     - out sequence matches input order across pointer wrap; no drops.
//  6 Reset pulse while 5 rows are queued, 0 popped.
//     - o_valid=0 during and after reset.
//     - The next full row written is popped first, with its own values.

Source files
------------

// File: rtl/psum_ofifo_pkg.sv
// Shared constants and helpers for the psum output FIFO.
// Default geometry matches an 8-wide MAC row producing dual 9-bit psums.
package psum_ofifo_pkg;

    localparam int unsigned COL      = 8;
    localparam int unsigned PSUM_BW  = 9;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned ENTRY_BW = 2 * PSUM_BW;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// Single-column synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
// i_rd must only be asserted for a legal pop (the top gates it with the all-columns-valid flag).
module psum_col_fifo
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned width = ENTRY_BW,
    parameter int unsigned depth = DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr,
    input  logic [width-1:0] i_data,
    input  logic             i_rd,
    output logic             o_empty,
    output logic             o_full,
    output logic [width-1:0] o_head
);

    localparam int unsigned AW = clog2(depth);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [width-1:0] r_mem [depth];
    logic             w_wr_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    // A full column still accepts a write when the head leaves on the same edge.
    assign w_wr_en = i_wr && (!o_full || i_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/psum_ofifo.sv
// Output FIFO behind the MAC row array: per-column skewed writes, aligned whole-row pops.
// Optional PSUM_OFIFO_ERR_EN adds a sticky overflow flag and a saturating dropped-write count.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned col     = COL,
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned depth   = DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2*psum_bw*col-1:0] in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [2*psum_bw*col-1:0] out,
    output logic                     o_valid,
    output logic                     o_ready,
    output logic                     o_full
`ifdef PSUM_OFIFO_ERR_EN
    ,
    output logic                     o_ovf,
    output logic [7:0]               o_drop_cnt
`endif
);

    localparam int unsigned EW = 2 * psum_bw;

    logic [col-1:0]    w_empty;
    logic [col-1:0]    w_full;
    logic [EW*col-1:0] w_head;
    logic              w_pop;
    logic [EW*col-1:0] r_out;

    for (genvar gi = 0; gi < col; gi++) begin : g_col
        psum_col_fifo #(
            .width (EW),
            .depth (depth)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_wr    (wr[gi]),
            .i_data  (in[gi*EW +: EW]),
            .i_rd    (w_pop),
            .o_empty (w_empty[gi]),
            .o_full  (w_full[gi]),
            .o_head  (w_head[gi*EW +: EW])
        );
    end

    assign o_valid = &(~w_empty);
    assign o_full  = |w_full;
    assign o_ready = ~o_full;
    assign w_pop   = rd && o_valid;
    assign out     = r_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out <= '0;
        end else if (w_pop) begin
            r_out <= w_head;
        end
    end

`ifdef PSUM_OFIFO_ERR_EN
    logic [col-1:0] w_drop;
    logic [31:0]    w_drop_num;
    logic [31:0]    w_cnt_sum;
    logic           r_ovf;
    logic [7:0]     r_drop_cnt;

    assign w_drop = wr & w_full & {col{~w_pop}};

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < col; i++) begin
            w_drop_num = w_drop_num + {31'd0, w_drop[i]};
        end
        w_cnt_sum = {24'd0, r_drop_cnt} + w_drop_num;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_ovf      <= r_ovf | (|w_drop);
            r_drop_cnt <= (w_cnt_sum > 32'd255) ? 8'd255 : w_cnt_sum[7:0];
        end
    end

    assign o_ovf      = r_ovf;
    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed self-checking bench for psum_ofifo: reset, skewed fill, full/drop, pop-while-full,
// pointer wrap streaming and mid-stream reset.
module tb_psum_ofifo;
    import psum_ofifo_pkg::*;

    localparam int unsigned EB = ENTRY_BW;
    localparam int unsigned W  = EB * COL;

    logic           clk;
    logic           reset;
    logic [W-1:0]   in_bus;
    logic [COL-1:0] wr;
    logic           rd;
    logic [W-1:0]   out_bus;
    logic           o_valid;
    logic           o_ready;
    logic           o_full;
`ifdef PSUM_OFIFO_ERR_EN
    logic           o_ovf;
    logic [7:0]     o_drop_cnt;
`endif

    int n_tests;
    int n_fail;

    psum_ofifo dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in_bus),
        .wr      (wr),
        .rd      (rd),
        .out     (out_bus),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_full  (o_full)
`ifdef PSUM_OFIFO_ERR_EN
        ,
        .o_ovf      (o_ovf),
        .o_drop_cnt (o_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] row_vec(input int k);
        logic [W-1:0] v;
        for (int i = 0; i < COL; i++) begin
            v[i*EB +: EB] = EB'(32'h200 + k * 8 + i);
        end
        return v;
    endfunction

    task automatic check_flags(input string name, input logic ev, input logic er,
                               input logic ef);
        n_tests++;
        if ({o_valid, o_ready, o_full} !== {ev, er, ef}) begin
            n_fail++;
            $display("FAIL %s: valid/ready/full got %b%b%b want %b%b%b", name,
                     o_valid, o_ready, o_full, ev, er, ef);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rd    = 1'b0;
        wr    = '1;
        for (int i = 0; i < COL; i++) in_bus[i*EB +: EB] = EB'(1);
        #2;
        tick();
        tick();
        check_flags("reset_flags", 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (out_bus !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got %h want 0", out_bus);
        end
        wr    = '0;
        reset = 1'b1;
        tick();
        check_flags("reset_release_nothing_written", 1'b0, 1'b1, 1'b0);
`ifdef PSUM_OFIFO_ERR_EN
        n_tests++;
        if ({o_ovf, o_drop_cnt} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_err: got ovf=%b cnt=%0d want 0/0", o_ovf, o_drop_cnt);
        end
`endif
    endtask

    task automatic test_skewed_fill();
        logic [W-1:0] exp;
        for (int i = 0; i < COL; i++) begin
            in_bus[i*EB +: EB] = EB'(8'h10 + i);
            exp[i*EB +: EB]    = EB'(8'h10 + i);
            wr = COL'(1 << i);
            tick();
            n_tests++;
            if (o_valid !== (i == COL - 1)) begin
                n_fail++;
                $display("FAIL skew_valid_col%0d: got %b want %b", i, o_valid, i == COL - 1);
            end
        end
        wr = '0;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        n_tests++;
        if (out_bus !== exp) begin
            n_fail++;
            $display("FAIL skew_out: got %h want %h", out_bus, exp);
        end
        check_flags("skew_after_pop", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_full_drop();
        wr = '1;
        in_bus[0 +: EB] = '0;
        for (int i = 1; i < COL; i++) in_bus[i*EB +: EB] = EB'(12'h100 + i);
        tick();
        wr = COL'(1);
        for (int k = 1; k < DEPTH; k++) begin
            in_bus[0 +: EB] = EB'(k);
            tick();
        end
        check_flags("full_after_16", 1'b1, 1'b0, 1'b1);
        in_bus[0 +: EB] = EB'(12'h3ff);
        tick();
        wr = '0;
        check_flags("full_after_drop", 1'b1, 1'b0, 1'b1);
`ifdef PSUM_OFIFO_ERR_EN
        n_tests++;
        if ({o_ovf, o_drop_cnt} !== {1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL drop_err: got ovf=%b cnt=%0d want 1/1", o_ovf, o_drop_cnt);
        end
`endif
    endtask

    task automatic test_pop_while_full();
        logic [W-1:0] exp;
        exp[0 +: EB] = '0;
        for (int i = 1; i < COL; i++) exp[i*EB +: EB] = EB'(12'h100 + i);
        wr = COL'(1);
        in_bus[0 +: EB] = EB'(12'h2aa);
        rd = 1'b1;
        tick();
        wr = '0;
        rd = 1'b0;
        n_tests++;
        if (out_bus !== exp) begin
            n_fail++;
            $display("FAIL popfull_out: got %h want %h", out_bus, exp);
        end
        // Col 0 still full means the same-cycle write landed; other columns drained.
        check_flags("popfull_flags", 1'b0, 1'b0, 1'b1);
`ifdef PSUM_OFIFO_ERR_EN
        n_tests++;
        if (o_drop_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL popfull_cnt: got %0d want 1", o_drop_cnt);
        end
`endif
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_wrap_stream();
        int written = 0;
        int popped  = 0;
        int cycles  = 0;
        int saw_full = 0;
        logic do_pop;
        while (popped < 40 && cycles < 200) begin
            if (written < 40) begin
                wr     = '1;
                in_bus = row_vec(written);
            end else begin
                wr = '0;
            end
            do_pop = o_valid;
            rd     = do_pop;
            tick();
            cycles++;
            if (written < 40) written++;
            if (o_full) saw_full++;
            if (do_pop) begin
                n_tests++;
                if (out_bus !== row_vec(popped)) begin
                    n_fail++;
                    $display("FAIL wrap_row%0d: got %h want %h", popped, out_bus,
                             row_vec(popped));
                end
                popped++;
            end
        end
        wr = '0;
        rd = 1'b0;
        n_tests++;
        if (popped != 40 || saw_full != 0) begin
            n_fail++;
            $display("FAIL wrap_count: got popped=%0d full_cycles=%0d want 40/0", popped,
                     saw_full);
        end
        check_flags("wrap_drained", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midstream();
        logic [W-1:0] fresh;
        for (int k = 0; k < 5; k++) begin
            wr     = '1;
            in_bus = row_vec(100 + k);
            tick();
        end
        wr = '0;
        check_flags("mid_queued", 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check_flags("mid_during_reset", 1'b0, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check_flags("mid_after_reset", 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (out_bus !== '0) begin
            n_fail++;
            $display("FAIL mid_out_cleared: got %h want 0", out_bus);
        end
        for (int i = 0; i < COL; i++) fresh[i*EB +: EB] = EB'(12'h060 + i);
        wr     = '1;
        in_bus = fresh;
        tick();
        wr = '0;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        n_tests++;
        if (out_bus !== fresh) begin
            n_fail++;
            $display("FAIL mid_first_pop: got %h want %h", out_bus, fresh);
        end
        check_flags("mid_empty_again", 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        in_bus  = '0;
        wr      = '0;
        rd      = 1'b0;
        reset   = 1'b0;
        test_reset();
        test_skewed_fill();
        test_full_drop();
        test_pop_while_full();
        test_wrap_stream();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
